// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounces three raw switches into one-cycle command pulses and
// drives the counter strobe (ci), display load (ld) and clear (clr) from a four-state FSM.
module stopwatch_ctrl #(
  parameter int unsigned DB_CNT = 4,
  parameter int unsigned DIV    = 10,
  parameter int unsigned PW     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       sw3,
  output logic       ci,
  output logic       ld,
  output logic       clr,
  output logic [1:0] state
);

  localparam int unsigned NSW = 3;
  localparam int unsigned DCW = (DB_CNT > 2) ? $clog2(DB_CNT) : 1;
  localparam logic [DCW-1:0] DC_MAX = DCW'(DB_CNT - 1);
  localparam logic [PW-1:0]  PS_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LAP  = 2'b10,
    ST_STOP = 2'b11
  } state_e;

  logic [NSW-1:0] raw;
  logic [NSW-1:0] sync1_q, s_q;
  logic [NSW-1:0] db_q, db_d, db_dly_q;
  logic [NSW-1:0] pulse;
  logic [DCW-1:0] dc_q [NSW];
  logic [DCW-1:0] dc_d [NSW];

  state_e         state_q, state_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           ci_q, ci_d;
  logic           ld_q, ld_d;
  logic           clr_q, clr_d;

  // Bit 0 = start/resume, bit 1 = stop, bit 2 = lap/clear.
  assign raw   = {sw3, sw2, sw1};
  assign pulse = db_q & ~db_dly_q;

  // Debounce: the level flips only after DB_CNT consecutive samples disagree with it.
  always_comb begin
    db_d = db_q;
    for (int unsigned i = 0; i < NSW; i++) begin
      dc_d[i] = '0;
      if (s_q[i] != db_q[i]) begin
        if (dc_q[i] == DC_MAX) begin
          db_d[i] = s_q[i];
        end else begin
          dc_d[i] = dc_q[i] + DCW'(1);
        end
      end
    end
  end

  // Next state; within each state the legal pulses are tested stop > lap/clear > start.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    clr_d   = 1'b0;

    if (state_q == ST_RUN || state_q == ST_LAP) begin
      presc_d = (presc_q == PS_MAX) ? '0 : presc_q + PW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (pulse[2]) begin
          clr_d = 1'b1;
        end else if (pulse[0]) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
      end
      ST_RUN: begin
        if (pulse[1])      state_d = ST_STOP;
        else if (pulse[2]) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (pulse[1])      state_d = ST_STOP;
        else if (pulse[2]) state_d = ST_RUN;
      end
      ST_STOP: begin
        if (pulse[2]) begin
          clr_d   = 1'b1;
          presc_d = '0;
          state_d = ST_IDLE;
        end else if (pulse[0]) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered copies of the decode of the next-state registers.
    ci_d = (state_d == ST_RUN || state_d == ST_LAP) && (presc_d == PS_MAX);
    ld_d = (state_d != ST_LAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      s_q      <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      for (int unsigned i = 0; i < NSW; i++) dc_q[i] <= '0;
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      ci_q     <= 1'b0;
      ld_q     <= 1'b1;
      clr_q    <= 1'b0;
    end else begin
      sync1_q  <= raw;
      s_q      <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      for (int unsigned i = 0; i < NSW; i++) dc_q[i] <= dc_d[i];
      state_q  <= state_d;
      presc_q  <= presc_d;
      ci_q     <= ci_d;
      ld_q     <= ld_d;
      clr_q    <= clr_d;
    end
  end

  assign ci    = ci_q;
  assign ld    = ld_q;
  assign clr   = clr_q;
  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: vector table, directed timing sequences and
// random switch activity compared every cycle against a sample-window reference model.
module tb_stopwatch_ctrl;

  localparam int DB   = 4;
  localparam int DIVV = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0;
  logic       ci, ld, clr;
  logic [1:0] state;

  int n_checks = 0, n_err = 0;
  int edge_n = 0, n_trans = 0, n_clr = 0, n_ci = 0;
  logic [1:0] prev_state = 2'b00;

  // Reference model: states 0 idle, 1 run, 2 lap, 3 stop; switch index 0 start, 1 stop, 2 lap/clear.
  int       m_state, m_phase;
  bit       m_ci, m_ld, m_clr;
  bit [2:0] m_sync1, m_db, m_dbd;
  bit       m_sh [3][DB];

  typedef struct {
    logic [2:0] sw;
    int         hold;
    int         exp_state;
    logic       exp_ld;
  } vec_t;
  vec_t vecs [14];

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DB_CNT(DB), .DIV(DIVV), .PW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw1   (sw1),
    .sw2   (sw2),
    .sw3   (sw3),
    .ci    (ci),
    .ld    (ld),
    .clr   (clr),
    .state (state)
  );

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Destination of command k from state st, or -1 when the command is ignored there.
  function automatic int legal_next(input int st, input int k);
    case (st)
      0:       return (k == 0) ? 1 : ((k == 2) ? 0 : -1);
      1:       return (k == 1) ? 3 : ((k == 2) ? 2 : -1);
      2:       return (k == 1) ? 3 : ((k == 2) ? 1 : -1);
      default: return (k == 0) ? 1 : ((k == 2) ? 0 : -1);
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_phase = 0;
    m_ci = 1'b0; m_ld = 1'b1; m_clr = 1'b0;
    m_sync1 = '0; m_db = '0; m_dbd = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < DB; j++) m_sh[i][j] = 1'b0;
  endtask

  task automatic model_edge(input bit [2:0] raw);
    bit [2:0] p;
    int       order [3] = '{1, 2, 0};
    int       act, ns;
    bit       flip;
    p   = m_db & ~m_dbd;
    act = -1;
    for (int o = 0; o < 3; o++)
      if (act < 0 && p[order[o]] && legal_next(m_state, order[o]) >= 0) act = order[o];
    ns    = (act >= 0) ? legal_next(m_state, act) : m_state;
    m_clr = (act == 2) && (m_state == 0 || m_state == 3);
    if (m_state == 1 || m_state == 2) m_phase = (m_phase + 1) % DIVV;
    if ((act == 0 && m_state == 0) || (act == 2 && m_state == 3)) m_phase = 0;
    // A debounced level flips when the last DB synchronized samples all disagree with it.
    m_dbd = m_db;
    for (int i = 0; i < 3; i++) begin
      flip = 1'b1;
      for (int j = 0; j < DB; j++) if (m_sh[i][j] == m_db[i]) flip = 1'b0;
      if (flip) m_db[i] = ~m_db[i];
      for (int j = DB - 1; j > 0; j--) m_sh[i][j] = m_sh[i][j-1];
      m_sh[i][0] = m_sync1[i];
    end
    m_sync1 = raw;
    m_state = ns;
    m_ld    = (ns != 2);
    m_ci    = (ns == 1 || ns == 2) && (m_phase == DIVV - 1);
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    if (!rst_n) model_reset();
    else        model_edge({sw3, sw2, sw1});
    #1;
    chk("state", int'(state), m_state);
    chk("ci",    int'(ci),    int'(m_ci));
    chk("ld",    int'(ld),    int'(m_ld));
    chk("clr",   int'(clr),   int'(m_clr));
    if (state != prev_state) n_trans++;
    prev_state = state;
    if (clr) n_clr++;
    if (ci)  n_ci++;
  endtask

  task automatic press(input logic [2:0] sw, input int n, input int idle);
    {sw3, sw2, sw1} = sw;
    repeat (n) step();
    {sw3, sw2, sw1} = 3'b000;
    repeat (idle) step();
  endtask

  // Starts from IDLE with sw1 pressed now; checks press latency and ci phase/cadence.
  task automatic measure_start(input string tag);
    int e0, lat, fci, sci;
    sw1 = 1'b1;
    e0 = edge_n; lat = 0; fci = 0; sci = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 20) sw1 = 1'b0;
      step();
      if (state == 2'b01 && lat == 0) lat = edge_n - e0;
      if (ci) begin
        if (fci == 0)      fci = edge_n - e0;
        else if (sci == 0) sci = edge_n - e0;
      end
    end
    chk({tag, "_latency"},   lat,       7);
    chk({tag, "_first_ci"},  fci,       16);
    chk({tag, "_ci_period"}, sci - fci, 10);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, last;
    vecs[0]  = '{3'b001, 20, 1, 1'b1};
    vecs[1]  = '{3'b100,  6, 2, 1'b0};
    vecs[2]  = '{3'b100,  6, 1, 1'b1};
    vecs[3]  = '{3'b010,  6, 3, 1'b1};
    vecs[4]  = '{3'b001,  3, 3, 1'b1};
    vecs[5]  = '{3'b001,  6, 1, 1'b1};
    vecs[6]  = '{3'b011,  6, 3, 1'b1};
    vecs[7]  = '{3'b100,  6, 0, 1'b1};
    vecs[8]  = '{3'b110,  6, 0, 1'b1};
    vecs[9]  = '{3'b001,  6, 1, 1'b1};
    vecs[10] = '{3'b101,  6, 2, 1'b0};
    vecs[11] = '{3'b010,  6, 3, 1'b1};
    vecs[12] = '{3'b010,  6, 3, 1'b1};
    vecs[13] = '{3'b101,  6, 0, 1'b1};

    model_reset();
    for (int k = 0; k < 6; k++) begin
      {sw3, sw2, sw1} = 3'($urandom_range(0, 7));
      step();
    end
    chk("rst_state", int'(state), 0);
    chk("rst_ld",    int'(ld),    1);
    {sw3, sw2, sw1} = 3'b000;
    rst_n = 1'b1;
    repeat (5) step();

    for (int v = 0; v < 14; v++) begin
      press(vecs[v].sw, vecs[v].hold, 12);
      chk($sformatf("vec%0d_state", v), int'(state), vecs[v].exp_state);
      chk($sformatf("vec%0d_ld", v),    int'(ld),    int'(vecs[v].exp_ld));
    end

    // Bouncy press: on 2, off 1, on 6.
    c0 = n_trans;
    sw1 = 1'b1; repeat (2) step();
    sw1 = 1'b0; step();
    sw1 = 1'b1; repeat (6) step();
    sw1 = 1'b0; repeat (12) step();
    chk("bouncy_transitions", n_trans - c0, 1);
    chk("bouncy_state", int'(state), 1);

    press(3'b010, 6, 12);
    chk("stop_state", int'(state), 3);
    c0 = n_ci;
    repeat (30) step();
    chk("stop_ci_quiet", n_ci - c0, 0);

    c0 = n_clr;
    press(3'b100, 6, 12);
    chk("clear_pulses", n_clr - c0, 1);
    chk("clear_state", int'(state), 0);

    measure_start("start");

    // Lap entered mid-run must not disturb the ci cadence.
    last = -1;
    sw3 = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (k == 6) sw3 = 1'b0;
      step();
      if (ci) begin
        if (last >= 0) chk("lap_ci_period", edge_n - last, 10);
        last = edge_n;
      end
    end
    chk("lap_state", int'(state), 2);
    chk("lap_ld",    int'(ld),    0);

    // Reset asserted mid-cycle while in LAP.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_ld",    int'(ld),    1);
    chk("async_ci",    int'(ci),    0);
    chk("async_clr",   int'(clr),   0);
    for (int k = 0; k < 6; k++) begin
      {sw3, sw2, sw1} = 3'($urandom_range(0, 7));
      step();
    end
    {sw3, sw2, sw1} = 3'b001;
    repeat (2) step();
    rst_n = 1'b1;
    measure_start("hold");

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) == 0) sw1 = ~sw1;
      if ($urandom_range(0, 9) == 0) sw2 = ~sw2;
      if ($urandom_range(0, 9) == 0) sw3 = ~sw3;
      rst_n = ($urandom_range(0, 999) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
